// File: rtl/cva6_obi_fetch_resp_buffer_if.sv
// Signal bundle for cva6_obi_fetch_resp_buffer: frontend fetch requests, OBI fetch port and buffered responses.
// The slave modport is the buffer's view; the master modport is the frontend/bus side.
interface cva6_obi_fetch_resp_buffer_if #(
    parameter int unsigned FETCH_WIDTH = 32,
    parameter int unsigned PLEN        = 34,
    parameter int unsigned ID_WIDTH    = 1,
    parameter int unsigned NR_ENTRIES  = 2
);
    localparam int unsigned CNT_W = $clog2(NR_ENTRIES + 1);

    logic                   flush_i;
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic [PLEN-1:0]        req_addr_i;
    logic                   obi_req_o;
    logic                   obi_gnt_i;
    logic [PLEN-1:0]        obi_addr_o;
    logic [ID_WIDTH-1:0]    obi_aid_o;
    logic                   obi_rvalid_i;
    logic                   obi_rready_o;
    logic [FETCH_WIDTH-1:0] obi_rdata_i;
    logic                   obi_err_i;
    logic                   rsp_valid_o;
    logic                   rsp_ready_i;
    logic [FETCH_WIDTH-1:0] rsp_data_o;
    logic [PLEN-1:0]        rsp_addr_o;
    logic                   rsp_err_o;
    logic [CNT_W-1:0]       outstanding_o;

    modport slave (
        input  flush_i, req_valid_i, req_addr_i, obi_gnt_i, obi_rvalid_i, obi_rdata_i,
               obi_err_i, rsp_ready_i,
        output req_ready_o, obi_req_o, obi_addr_o, obi_aid_o, obi_rready_o, rsp_valid_o,
               rsp_data_o, rsp_addr_o, rsp_err_o, outstanding_o
    );

    modport master (
        output flush_i, req_valid_i, req_addr_i, obi_gnt_i, obi_rvalid_i, obi_rdata_i,
               obi_err_i, rsp_ready_i,
        input  req_ready_o, obi_req_o, obi_addr_o, obi_aid_o, obi_rready_o, rsp_valid_o,
               rsp_data_o, rsp_addr_o, rsp_err_o, outstanding_o
    );
endinterface

// File: rtl/cva6_obi_fetch_resp_buffer.sv
// Bridges frontend fetch requests to an OBI fetch port, buffering responses in order and dropping flushed ones.
// Optional macro CVA6_OBI_FETCH_ERR_EN stores obi_err_i per entry and presents it on rsp_err_o.
module cva6_obi_fetch_resp_buffer #(
    parameter int unsigned FETCH_WIDTH = 32,
    parameter int unsigned PLEN        = 34,
    parameter int unsigned ID_WIDTH    = 1,
    parameter int unsigned NR_ENTRIES  = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    cva6_obi_fetch_resp_buffer_if.slave  bus
);
    localparam int unsigned CNT_W  = $clog2(NR_ENTRIES + 1);
    localparam int unsigned USED_W = CNT_W + 1;
    localparam int unsigned PTR_W  = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_KILL = 2'd2
    } state_e;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(NR_ENTRIES - 1)) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1'b1);
        end
        return n;
    endfunction

    state_e                 state_r;
    state_e                 state_nxt_s;
    logic [PLEN-1:0]        addr_r;
    logic [CNT_W-1:0]       outstanding_r;
    logic [CNT_W-1:0]       kill_cnt_r;
    logic [CNT_W-1:0]       out_nxt_s;
    logic [CNT_W-1:0]       kill_nxt_s;
    logic [USED_W-1:0]      used_s;

    logic [PLEN-1:0]        a_mem_r [NR_ENTRIES];
    logic [PTR_W-1:0]       a_wr_ptr_r;
    logic [PTR_W-1:0]       a_rd_ptr_r;

    logic [FETCH_WIDTH-1:0] d_mem_r [NR_ENTRIES];
    logic [PLEN-1:0]        ra_mem_r [NR_ENTRIES];
`ifdef CVA6_OBI_FETCH_ERR_EN
    logic                   e_mem_r [NR_ENTRIES];
`else
    logic                   err_unused_s;
`endif
    logic [PTR_W-1:0]       r_wr_ptr_r;
    logic [PTR_W-1:0]       r_rd_ptr_r;
    logic [CNT_W-1:0]       rsp_cnt_r;
    logic [CNT_W-1:0]       rsp_cnt_nxt_s;

    logic                   req_ready_s;
    logic                   accept_s;
    logic                   obi_req_s;
    logic                   gnt_s;
    logic                   rvalid_s;
    logic                   drop_s;
    logic                   keep_s;
    logic                   rsp_empty_s;
    logic                   rsp_valid_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   fifo_pop_s;
    logic [FETCH_WIDTH-1:0] rsp_data_s;
    logic [PLEN-1:0]        rsp_addr_s;
    logic                   rsp_err_s;

    // Credit accounting and handshake qualification.
    always_comb begin
        used_s      = USED_W'(outstanding_r) + USED_W'(rsp_cnt_r)
                    + ((state_r == ST_ADDR) ? USED_W'(1'b1) : USED_W'(1'b0));
        req_ready_s = (state_r == ST_IDLE) && (used_s < USED_W'(NR_ENTRIES))
                    && !bus.flush_i && !rst_i;
        accept_s    = bus.req_valid_i && req_ready_s;
        gnt_s       = bus.obi_gnt_i && (state_r != ST_IDLE);
        // Responses without an outstanding transaction are a bus protocol error and are ignored.
        rvalid_s    = bus.obi_rvalid_i && (outstanding_r != {CNT_W{1'b0}});
        drop_s      = rvalid_s && (kill_cnt_r != {CNT_W{1'b0}});
        keep_s      = rvalid_s && !drop_s && !bus.flush_i;
    end

    // Address-phase FSM: next state and OBI request.
    always_comb begin
        state_nxt_s = state_r;
        obi_req_s   = (state_r != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_ADDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                // A pending request cannot be retracted, so a flush parks it in KILL until granted.
                if (gnt_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus.flush_i) begin
                    state_nxt_s = ST_KILL;
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_KILL: begin
                if (gnt_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_KILL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                obi_req_s   = 1'b0;
            end
        endcase
    end

    // Next values of the outstanding and kill counters.
    always_comb begin
        out_nxt_s = outstanding_r + (gnt_s ? CNT_W'(1'b1) : CNT_W'(1'b0))
                  - (rvalid_s ? CNT_W'(1'b1) : CNT_W'(1'b0));
        if (bus.flush_i) begin
            // Everything still in flight after this cycle belongs to flushed requests.
            kill_nxt_s = out_nxt_s;
        end else begin
            kill_nxt_s = kill_cnt_r - (drop_s ? CNT_W'(1'b1) : CNT_W'(1'b0))
                       + ((gnt_s && (state_r == ST_KILL)) ? CNT_W'(1'b1) : CNT_W'(1'b0));
        end
    end

    // Response FIFO control; an empty FIFO lets a kept response through in the same cycle.
    always_comb begin
        rsp_empty_s = (rsp_cnt_r == {CNT_W{1'b0}});
        rsp_valid_s = (!rsp_empty_s || keep_s) && !bus.flush_i;
        pop_s       = rsp_valid_s && bus.rsp_ready_i;
        push_s      = keep_s && !(rsp_empty_s && bus.rsp_ready_i);
        fifo_pop_s  = pop_s && !rsp_empty_s;
        if (bus.flush_i) begin
            rsp_cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            rsp_cnt_nxt_s = rsp_cnt_r + (push_s ? CNT_W'(1'b1) : CNT_W'(1'b0))
                          - (fifo_pop_s ? CNT_W'(1'b1) : CNT_W'(1'b0));
        end
    end

    // Response output mux, zeroed whenever no response is offered.
    always_comb begin
        rsp_data_s = {FETCH_WIDTH{1'b0}};
        rsp_addr_s = {PLEN{1'b0}};
        rsp_err_s  = 1'b0;
        if (!rsp_valid_s) begin
            rsp_data_s = {FETCH_WIDTH{1'b0}};
            rsp_addr_s = {PLEN{1'b0}};
            rsp_err_s  = 1'b0;
        end else if (rsp_empty_s) begin
            rsp_data_s = bus.obi_rdata_i;
            rsp_addr_s = a_mem_r[a_rd_ptr_r];
`ifdef CVA6_OBI_FETCH_ERR_EN
            rsp_err_s  = bus.obi_err_i;
`else
            rsp_err_s  = 1'b0;
`endif
        end else begin
            rsp_data_s = d_mem_r[r_rd_ptr_r];
            rsp_addr_s = ra_mem_r[r_rd_ptr_r];
`ifdef CVA6_OBI_FETCH_ERR_EN
            rsp_err_s  = e_mem_r[r_rd_ptr_r];
`else
            rsp_err_s  = 1'b0;
`endif
        end
    end

`ifndef CVA6_OBI_FETCH_ERR_EN
    assign err_unused_s = bus.obi_err_i;
`endif

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latched fetch address, held on the bus until granted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_r <= {PLEN{1'b0}};
        end else if (accept_s) begin
            addr_r <= bus.req_addr_i;
        end else begin
            addr_r <= addr_r;
        end
    end

    // Outstanding and kill counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_r <= {CNT_W{1'b0}};
            kill_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            outstanding_r <= out_nxt_s;
            kill_cnt_r    <= kill_nxt_s;
        end
    end

    // In-flight address FIFO pointers; its occupancy equals outstanding_r.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_wr_ptr_r <= {PTR_W{1'b0}};
            a_rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            a_wr_ptr_r <= gnt_s ? ptr_inc(a_wr_ptr_r) : a_wr_ptr_r;
            a_rd_ptr_r <= rvalid_s ? ptr_inc(a_rd_ptr_r) : a_rd_ptr_r;
        end
    end

    // In-flight address FIFO storage.
    always_ff @(posedge clk_i) begin
        if (gnt_s) begin
            a_mem_r[a_wr_ptr_r] <= addr_r;
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            r_wr_ptr_r <= {PTR_W{1'b0}};
            r_rd_ptr_r <= {PTR_W{1'b0}};
            rsp_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            r_wr_ptr_r <= push_s ? ptr_inc(r_wr_ptr_r) : r_wr_ptr_r;
            r_rd_ptr_r <= fifo_pop_s ? ptr_inc(r_rd_ptr_r) : r_rd_ptr_r;
            rsp_cnt_r  <= rsp_cnt_nxt_s;
        end
    end

    // Response FIFO storage.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            d_mem_r[r_wr_ptr_r]  <= bus.obi_rdata_i;
            ra_mem_r[r_wr_ptr_r] <= a_mem_r[a_rd_ptr_r];
`ifdef CVA6_OBI_FETCH_ERR_EN
            e_mem_r[r_wr_ptr_r]  <= bus.obi_err_i;
`endif
        end
    end

    assign bus.req_ready_o   = req_ready_s;
    assign bus.obi_req_o     = obi_req_s;
    assign bus.obi_addr_o    = addr_r;
    assign bus.obi_aid_o     = {ID_WIDTH{1'b0}};
    assign bus.obi_rready_o  = 1'b1;
    assign bus.rsp_valid_o   = rsp_valid_s;
    assign bus.rsp_data_o    = rsp_data_s;
    assign bus.rsp_addr_o    = rsp_addr_s;
    assign bus.rsp_err_o     = rsp_err_s;
    assign bus.outstanding_o = outstanding_r;

    cva6_obi_fetch_resp_buffer_chk #(
        .PLEN       (PLEN),
        .NR_ENTRIES (NR_ENTRIES)
    ) u_chk (
        .clk         (clk_i),
        .rst         (rst_i),
        .obi_req     (obi_req_s),
        .obi_gnt     (bus.obi_gnt_i),
        .obi_addr    (addr_r),
        .obi_rvalid  (bus.obi_rvalid_i),
        .outstanding (outstanding_r)
    );
endmodule

// Protocol checker for the OBI side of the fetch response buffer.
module cva6_obi_fetch_resp_buffer_chk #(
    parameter int unsigned PLEN       = 34,
    parameter int unsigned NR_ENTRIES = 2
) (
    input logic                               clk,
    input logic                               rst,
    input logic                               obi_req,
    input logic                               obi_gnt,
    input logic [PLEN-1:0]                    obi_addr,
    input logic                               obi_rvalid,
    input logic [$clog2(NR_ENTRIES + 1)-1:0]  outstanding
);
    a_rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (rst) obi_rvalid |-> (outstanding != '0)
    ) else $error("obi_rvalid without an outstanding transaction");

    a_req_held_until_gnt: assert property (
        @(posedge clk) disable iff (rst)
        $past(obi_req && !obi_gnt) |-> (obi_req && (obi_addr == $past(obi_addr)))
    ) else $error("OBI request retracted or address changed before grant");

    a_outstanding_bounded: assert property (
        @(posedge clk) disable iff (rst) outstanding <= NR_ENTRIES
    ) else $error("outstanding count exceeds credit limit");
endmodule

// File: tb/tb_cva6_obi_fetch_resp_buffer.sv
// Directed self-checking bench for cva6_obi_fetch_resp_buffer; inputs change on negedge, outputs checked 1 unit later.
module tb_cva6_obi_fetch_resp_buffer;
    localparam int unsigned FETCH_WIDTH = 32;
    localparam int unsigned PLEN        = 34;
    localparam int unsigned ID_WIDTH    = 1;
    localparam int unsigned NR_ENTRIES  = 2;

`ifdef CVA6_OBI_FETCH_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    cva6_obi_fetch_resp_buffer_if #(
        .FETCH_WIDTH (FETCH_WIDTH), .PLEN (PLEN), .ID_WIDTH (ID_WIDTH), .NR_ENTRIES (NR_ENTRIES)
    ) bus ();

    cva6_obi_fetch_resp_buffer #(
        .FETCH_WIDTH (FETCH_WIDTH), .PLEN (PLEN), .ID_WIDTH (ID_WIDTH), .NR_ENTRIES (NR_ENTRIES)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic fetch(input logic [PLEN-1:0] addr);
        @(negedge clk); bus.req_valid_i = 1'b1; bus.req_addr_i = addr;
        @(negedge clk); bus.req_valid_i = 1'b0; bus.obi_gnt_i = 1'b1;
        @(negedge clk); bus.obi_gnt_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.flush_i = 1'b0; bus.req_valid_i = 1'b0; bus.req_addr_i = '0;
        bus.obi_gnt_i = 1'b0; bus.obi_rvalid_i = 1'b0; bus.obi_rdata_i = '0;
        bus.obi_err_i = 1'b0; bus.rsp_ready_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.req_ready_o !== 1'b0) begin fails++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready_o); end
        checks++; if (bus.obi_req_o !== 1'b0) begin fails++; $display("FAIL reset_obi_req: got %b want 0", bus.obi_req_o); end
        checks++; if (bus.obi_addr_o !== 34'h0) begin fails++; $display("FAIL reset_obi_addr: got %h want 0", bus.obi_addr_o); end
        checks++; if (bus.obi_aid_o !== 1'b0) begin fails++; $display("FAIL reset_obi_aid: got %h want 0", bus.obi_aid_o); end
        checks++; if (bus.obi_rready_o !== 1'b1) begin fails++; $display("FAIL reset_obi_rready: got %b want 1", bus.obi_rready_o); end
        checks++; if (bus.rsp_valid_o !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid_o); end
        checks++; if (bus.rsp_data_o !== 32'h0) begin fails++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data_o); end
        checks++; if (bus.rsp_addr_o !== 34'h0) begin fails++; $display("FAIL reset_rsp_addr: got %h want 0", bus.rsp_addr_o); end
        checks++; if (bus.rsp_err_o !== 1'b0) begin fails++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err_o); end
        checks++; if (bus.outstanding_o !== 2'd0) begin fails++; $display("FAIL reset_outstanding: got %0d want 0", bus.outstanding_o); end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (bus.req_ready_o !== 1'b1) begin fails++; $display("FAIL post_reset_req_ready: got %b want 1", bus.req_ready_o); end
    endtask

    task automatic test_single_fetch();
        @(negedge clk); bus.req_valid_i = 1'b1; bus.req_addr_i = 34'h0_8000_0000; #1;
        checks++; if (bus.req_ready_o !== 1'b1) begin fails++; $display("FAIL single_req_ready: got %b want 1", bus.req_ready_o); end
        @(negedge clk); bus.req_valid_i = 1'b0; bus.obi_gnt_i = 1'b1; #1;
        checks++; if (bus.obi_req_o !== 1'b1) begin fails++; $display("FAIL single_obi_req: got %b want 1", bus.obi_req_o); end
        checks++; if (bus.obi_addr_o !== 34'h0_8000_0000) begin fails++; $display("FAIL single_obi_addr: got %h want 080000000", bus.obi_addr_o); end
        @(negedge clk); bus.obi_gnt_i = 1'b0; #1;
        checks++; if (bus.obi_req_o !== 1'b0) begin fails++; $display("FAIL single_req_drop: got %b want 0", bus.obi_req_o); end
        checks++; if (bus.outstanding_o !== 2'd1) begin fails++; $display("FAIL single_outstanding: got %0d want 1", bus.outstanding_o); end
        @(negedge clk);
        @(negedge clk); bus.obi_rvalid_i = 1'b1; bus.obi_rdata_i = 32'h0000_0013; #1;
        checks++; if (bus.rsp_valid_o !== 1'b1) begin fails++; $display("FAIL single_rsp_valid: got %b want 1", bus.rsp_valid_o); end
        checks++; if (bus.rsp_data_o !== 32'h0000_0013) begin fails++; $display("FAIL single_rsp_data: got %h want 00000013", bus.rsp_data_o); end
        checks++; if (bus.rsp_addr_o !== 34'h0_8000_0000) begin fails++; $display("FAIL single_rsp_addr: got %h want 080000000", bus.rsp_addr_o); end
        @(negedge clk); bus.obi_rvalid_i = 1'b0; bus.obi_rdata_i = 32'h0; bus.rsp_ready_i = 1'b1; #1;
        checks++; if (bus.rsp_data_o !== 32'h0000_0013) begin fails++; $display("FAIL single_buffered_data: got %h want 00000013", bus.rsp_data_o); end
        checks++; if (bus.outstanding_o !== 2'd0) begin fails++; $display("FAIL single_outstanding_done: got %0d want 0", bus.outstanding_o); end
        @(negedge clk); bus.rsp_ready_i = 1'b0; #1;
        checks++; if (bus.rsp_valid_o !== 1'b0) begin fails++; $display("FAIL single_rsp_empty: got %b want 0", bus.rsp_valid_o); end
    endtask

    task automatic test_credit_limit();
        fetch(34'h1000);
        fetch(34'h1004);
        bus.req_valid_i = 1'b1; bus.req_addr_i = 34'h1008; #1;
        checks++; if (bus.req_ready_o !== 1'b0) begin fails++; $display("FAIL credit_two_inflight: got %b want 0", bus.req_ready_o); end
        @(negedge clk); bus.obi_rvalid_i = 1'b1; bus.obi_rdata_i = 32'hA; #1;
        checks++; if (bus.req_ready_o !== 1'b0) begin fails++; $display("FAIL credit_first_rvalid: got %b want 0", bus.req_ready_o); end
        @(negedge clk); bus.obi_rdata_i = 32'hB; #1;
        checks++; if (bus.req_ready_o !== 1'b0) begin fails++; $display("FAIL credit_second_rvalid: got %b want 0", bus.req_ready_o); end
        @(negedge clk); bus.obi_rvalid_i = 1'b0; #1;
        checks++; if (bus.req_ready_o !== 1'b0) begin fails++; $display("FAIL credit_full: got %b want 0", bus.req_ready_o); end
        checks++; if (bus.rsp_data_o !== 32'hA) begin fails++; $display("FAIL credit_head_a: got %h want a", bus.rsp_data_o); end
        @(negedge clk); bus.rsp_ready_i = 1'b1; #1;
        checks++; if (bus.req_ready_o !== 1'b0) begin fails++; $display("FAIL credit_pop_cycle: got %b want 0", bus.req_ready_o); end
        @(negedge clk); bus.rsp_ready_i = 1'b0; #1;
        checks++; if (bus.req_ready_o !== 1'b1) begin fails++; $display("FAIL credit_after_pop: got %b want 1", bus.req_ready_o); end
        @(negedge clk); bus.req_valid_i = 1'b0; bus.obi_gnt_i = 1'b1; #1;
        checks++; if (bus.obi_addr_o !== 34'h1008) begin fails++; $display("FAIL credit_third_addr: got %h want 1008", bus.obi_addr_o); end
        @(negedge clk); bus.obi_gnt_i = 1'b0; bus.obi_rvalid_i = 1'b1; bus.obi_rdata_i = 32'hC; #1;
        checks++; if (bus.rsp_data_o !== 32'hB) begin fails++; $display("FAIL credit_head_b: got %h want b", bus.rsp_data_o); end
        @(negedge clk); bus.obi_rvalid_i = 1'b0; bus.rsp_ready_i = 1'b1; #1;
        checks++; if (bus.rsp_addr_o !== 34'h1004) begin fails++; $display("FAIL credit_addr_b: got %h want 1004", bus.rsp_addr_o); end
        @(negedge clk); #1;
        checks++; if (bus.rsp_data_o !== 32'hC) begin fails++; $display("FAIL credit_data_c: got %h want c", bus.rsp_data_o); end
        checks++; if (bus.rsp_addr_o !== 34'h1008) begin fails++; $display("FAIL credit_addr_c: got %h want 1008", bus.rsp_addr_o); end
        @(negedge clk); bus.rsp_ready_i = 1'b0; #1;
        checks++; if (bus.rsp_valid_o !== 1'b0) begin fails++; $display("FAIL credit_drained: got %b want 0", bus.rsp_valid_o); end
    endtask

    task automatic test_flush_outstanding();
        fetch(34'h200);
        fetch(34'h204);
        bus.flush_i = 1'b1; #1;
        checks++; if (bus.req_ready_o !== 1'b0) begin fails++; $display("FAIL flush_req_ready: got %b want 0", bus.req_ready_o); end
        @(negedge clk); bus.flush_i = 1'b0; #1;
        checks++; if (bus.outstanding_o !== 2'd2) begin fails++; $display("FAIL flush_outstanding: got %0d want 2", bus.outstanding_o); end
        @(negedge clk); bus.obi_rvalid_i = 1'b1; bus.obi_rdata_i = 32'hDEAD; #1;
        checks++; if (bus.rsp_valid_o !== 1'b0) begin fails++; $display("FAIL flush_drop_first: got %b want 0", bus.rsp_valid_o); end
        @(negedge clk); bus.obi_rdata_i = 32'hBEEF; #1;
        checks++; if (bus.rsp_valid_o !== 1'b0) begin fails++; $display("FAIL flush_drop_second: got %b want 0", bus.rsp_valid_o); end
        @(negedge clk); bus.obi_rvalid_i = 1'b0; #1;
        checks++; if (bus.rsp_valid_o !== 1'b0) begin fails++; $display("FAIL flush_nothing_buffered: got %b want 0", bus.rsp_valid_o); end
        checks++; if (bus.outstanding_o !== 2'd0) begin fails++; $display("FAIL flush_outstanding_zero: got %0d want 0", bus.outstanding_o); end
        fetch(34'h100);
        @(negedge clk); bus.obi_rvalid_i = 1'b1; bus.obi_rdata_i = 32'hABCD; bus.rsp_ready_i = 1'b1; #1;
        checks++; if (bus.rsp_valid_o !== 1'b1) begin fails++; $display("FAIL flush_new_valid: got %b want 1", bus.rsp_valid_o); end
        checks++; if (bus.rsp_data_o !== 32'hABCD) begin fails++; $display("FAIL flush_new_data: got %h want abcd", bus.rsp_data_o); end
        checks++; if (bus.rsp_addr_o !== 34'h100) begin fails++; $display("FAIL flush_new_addr: got %h want 100", bus.rsp_addr_o); end
        @(negedge clk); bus.obi_rvalid_i = 1'b0; bus.rsp_ready_i = 1'b0; #1;
        checks++; if (bus.rsp_valid_o !== 1'b0) begin fails++; $display("FAIL flush_new_consumed: got %b want 0", bus.rsp_valid_o); end
    endtask

    task automatic test_flush_in_addr();
        @(negedge clk); bus.req_valid_i = 1'b1; bus.req_addr_i = 34'h300;
        @(negedge clk); bus.req_valid_i = 1'b0; bus.flush_i = 1'b1; #1;
        checks++; if (bus.obi_req_o !== 1'b1) begin fails++; $display("FAIL kill_req_flush_cycle: got %b want 1", bus.obi_req_o); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); bus.flush_i = 1'b0; #1;
            checks++; if (bus.obi_req_o !== 1'b1) begin fails++; $display("FAIL kill_req_held[%0d]: got %b want 1", i, bus.obi_req_o); end
            checks++; if (bus.obi_addr_o !== 34'h300) begin fails++; $display("FAIL kill_addr_stable[%0d]: got %h want 300", i, bus.obi_addr_o); end
        end
        @(negedge clk); bus.obi_gnt_i = 1'b1; #1;
        checks++; if (bus.obi_req_o !== 1'b1) begin fails++; $display("FAIL kill_req_at_gnt: got %b want 1", bus.obi_req_o); end
        @(negedge clk); bus.obi_gnt_i = 1'b0; #1;
        checks++; if (bus.obi_req_o !== 1'b0) begin fails++; $display("FAIL kill_req_released: got %b want 0", bus.obi_req_o); end
        checks++; if (bus.outstanding_o !== 2'd1) begin fails++; $display("FAIL kill_outstanding_one: got %0d want 1", bus.outstanding_o); end
        @(negedge clk); bus.obi_rvalid_i = 1'b1; bus.obi_rdata_i = 32'h5555; #1;
        checks++; if (bus.rsp_valid_o !== 1'b0) begin fails++; $display("FAIL kill_rsp_dropped: got %b want 0", bus.rsp_valid_o); end
        @(negedge clk); bus.obi_rvalid_i = 1'b0; #1;
        checks++; if (bus.outstanding_o !== 2'd0) begin fails++; $display("FAIL kill_outstanding_zero: got %0d want 0", bus.outstanding_o); end
        checks++; if (bus.rsp_valid_o !== 1'b0) begin fails++; $display("FAIL kill_nothing_buffered: got %b want 0", bus.rsp_valid_o); end
    endtask

    task automatic test_back_to_back();
        fetch(34'h10);
        fetch(34'h14);
        bus.obi_rvalid_i = 1'b1; bus.obi_rdata_i = 32'h10;
        @(negedge clk); bus.obi_rdata_i = 32'h14;
        @(negedge clk); bus.obi_rvalid_i = 1'b0; #1;
        checks++; if (bus.rsp_data_o !== 32'h10) begin fails++; $display("FAIL b2b_head_10: got %h want 10", bus.rsp_data_o); end
        checks++; if (bus.req_ready_o !== 1'b0) begin fails++; $display("FAIL b2b_full_ready: got %b want 0", bus.req_ready_o); end
        @(negedge clk); bus.rsp_ready_i = 1'b1;
        @(negedge clk); bus.rsp_ready_i = 1'b0; bus.req_valid_i = 1'b1; bus.req_addr_i = 34'h18; #1;
        checks++; if (bus.rsp_data_o !== 32'h14) begin fails++; $display("FAIL b2b_head_14: got %h want 14", bus.rsp_data_o); end
        checks++; if (bus.req_ready_o !== 1'b1) begin fails++; $display("FAIL b2b_refill_ready: got %b want 1", bus.req_ready_o); end
        @(negedge clk); bus.req_valid_i = 1'b0; bus.obi_gnt_i = 1'b1;
        @(negedge clk); bus.obi_gnt_i = 1'b0; bus.obi_rvalid_i = 1'b1; bus.obi_rdata_i = 32'h18; bus.rsp_ready_i = 1'b1; #1;
        checks++; if (bus.rsp_data_o !== 32'h14) begin fails++; $display("FAIL b2b_push_pop_head: got %h want 14", bus.rsp_data_o); end
        @(negedge clk); bus.obi_rvalid_i = 1'b0; bus.rsp_ready_i = 1'b0; #1;
        checks++; if (bus.rsp_data_o !== 32'h18) begin fails++; $display("FAIL b2b_data_18: got %h want 18", bus.rsp_data_o); end
        checks++; if (bus.rsp_addr_o !== 34'h18) begin fails++; $display("FAIL b2b_addr_18: got %h want 18", bus.rsp_addr_o); end
        fetch(34'h1C);
        bus.obi_rvalid_i = 1'b1; bus.obi_rdata_i = 32'h1C;
        @(negedge clk); bus.obi_rvalid_i = 1'b0; #1;
        checks++; if (bus.req_ready_o !== 1'b0) begin fails++; $display("FAIL b2b_full_again: got %b want 0", bus.req_ready_o); end
        @(negedge clk); bus.flush_i = 1'b1; #1;
        checks++; if (bus.rsp_valid_o !== 1'b0) begin fails++; $display("FAIL b2b_flush_cycle_valid: got %b want 0", bus.rsp_valid_o); end
        @(negedge clk); bus.flush_i = 1'b0; #1;
        checks++; if (bus.req_ready_o !== 1'b1) begin fails++; $display("FAIL b2b_credits_freed: got %b want 1", bus.req_ready_o); end
        checks++; if (bus.rsp_valid_o !== 1'b0) begin fails++; $display("FAIL b2b_flushed_empty: got %b want 0", bus.rsp_valid_o); end
    endtask

    task automatic test_error();
        fetch(34'h400);
        bus.obi_rvalid_i = 1'b1; bus.obi_rdata_i = 32'h77; bus.obi_err_i = 1'b1; #1;
        checks++; if (bus.rsp_err_o !== ERR_EXP) begin fails++; $display("FAIL err_bypass: got %b want %b", bus.rsp_err_o, ERR_EXP); end
        @(negedge clk); bus.obi_rvalid_i = 1'b0; bus.obi_err_i = 1'b0; #1;
        checks++; if (bus.rsp_err_o !== ERR_EXP) begin fails++; $display("FAIL err_stored: got %b want %b", bus.rsp_err_o, ERR_EXP); end
        checks++; if (bus.rsp_data_o !== 32'h77) begin fails++; $display("FAIL err_data: got %h want 77", bus.rsp_data_o); end
        @(negedge clk); bus.rsp_ready_i = 1'b1;
        @(negedge clk); bus.rsp_ready_i = 1'b0; #1;
        checks++; if (bus.rsp_valid_o !== 1'b0) begin fails++; $display("FAIL err_drained: got %b want 0", bus.rsp_valid_o); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_credit_limit();
        test_flush_outstanding();
        test_flush_in_addr();
        test_back_to_back();
        test_error();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
